// File: rtl/jk_counter_reg.sv
// Bank of WIDTH JK flip-flops with sync reset, parallel load, clock enable and up/down count.
// Define JKC_SATURATE_EN to make the counter modes saturate instead of wrapping.
module jk_counter_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    typedef enum logic [1:0] {
        MODE_JK   = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    mode_e            mode_s;
    logic [WIDTH-1:0] carry_up;
    logic [WIDTH-1:0] carry_dn;
    logic [WIDTH-1:0] jj;
    logic [WIDTH-1:0] kk;
    logic [WIDTH-1:0] q_next;
    logic             wrap_next;

    assign mode_s = mode_e'(mode);

    // Toggle masks of an increment/decrement: bit i set iff all lower bits are 1 (up) or 0 (down).
    assign carry_up = q ^ (q + ONE);
    assign carry_dn = q ^ (q - ONE);

    assign tc = ((mode_s == MODE_UP) && (&q)) || ((mode_s == MODE_DOWN) && ~(|q));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        jj = '0;
        kk = '0;
        unique case (mode_s)
            MODE_JK:   begin jj = j;        kk = k;        end
            MODE_UP:   begin jj = carry_up; kk = carry_up; end
            MODE_DOWN: begin jj = carry_dn; kk = carry_dn; end
            MODE_HOLD: begin jj = '0;       kk = '0;       end
        endcase
`ifdef JKC_SATURATE_EN
        if (tc) begin
            jj = '0;
            kk = '0;
        end
`endif
    end

    // JK characteristic equation, applied to every cell in parallel.
    assign q_next = (jj & ~q) | (~kk & q);

`ifdef JKC_SATURATE_EN
    assign wrap_next = 1'b0;
`else
    assign wrap_next = tc;
`endif

    // NOTE: state registers use non-blocking assignments so all cells update together on the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= '0;
            wrap <= 1'b0;
        end else if (load) begin
            q    <= load_val;
            wrap <= 1'b0;
        end else if (en) begin
            q    <= q_next;
            wrap <= wrap_next;
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule
